// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, memory size codes, FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ST_HI,
    LD_CAP,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
  } lsu_req_t;

  // Memory size code for a legal, unsplit store.
  function automatic logic [2:0] store_size(input logic [2:0] funct3);
    case (funct3)
      F3_H:    store_size = SZ_H;
      F3_W:    store_size = SZ_W;
      default: store_size = SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Lane select plus sign/zero extension of an aligned memory word; purely combinational.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'b0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'b0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator; accept-to-response: load 3, store 2, split half store 3, error 1 cycle.
// One request in flight, req_ready only in IDLE; the response pulse has no backpressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  MemSize,
  output logic [31:0] A_Ram,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  lsu_state_t  state;
  lsu_req_t    req_q;
  logic [7:0]  wdata_hi;
  logic        req_err;
  logic [32:0] last_byte;
  logic [31:0] ld_data;
  logic        accept;
  logic        split_in;

  assign accept = req_valid && req_ready;
  // Memory only honours halfwords at offset 0, so offset-2 halfword stores go out as two bytes.
  assign split_in = (req_funct3 == F3_H) && req_addr[1];

  always_comb begin
    last_byte = {1'b0, req_addr} + ((req_funct3 == F3_W) ? 33'd3 : 33'd0);
    req_err   = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = req_addr[0];
      F3_W:        req_err = |req_addr[1:0];
      default:     req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if (last_byte >= 33'(MEM_BYTES)) req_err = 1'b1;
  end

  lsu_load_extract u_extract (
    .rdata  (ReadData),
    .offset (req_q.addr[1:0]),
    .funct3 (req_q.funct3),
    .result (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      req_q     <= '0;
      wdata_hi  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      MemSize   <= SZ_B;
      A_Ram     <= '0;
      WriteData <= '0;
    end else begin
      rsp_valid <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_q     <= '{we: req_we, funct3: req_funct3, addr: req_addr};
          wdata_hi  <= req_wdata[15:8];
          req_ready <= 1'b0;
          if (req_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= ISSUE;
            if (req_we) begin
              MemWrite <= 1'b1;
              A_Ram    <= req_addr;
              if (split_in) begin
                MemSize   <= SZ_B;
                WriteData <= {24'b0, req_wdata[7:0]};
              end else begin
                MemSize   <= store_size(req_funct3);
                WriteData <= req_wdata;
              end
            end else begin
              MemRead <= 1'b1;
              MemSize <= SZ_W;
              A_Ram   <= {req_addr[31:2], 2'b00};
            end
          end
        end
        ISSUE: begin
          if (!req_q.we) begin
            state <= LD_CAP;
          end else if ((req_q.funct3 == F3_H) && req_q.addr[1]) begin
            state     <= ST_HI;
            MemWrite  <= 1'b1;
            MemSize   <= SZ_B;
            A_Ram     <= req_q.addr + 32'd1;
            WriteData <= {24'b0, wdata_hi};
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        ST_HI: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        LD_CAP: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a byte-addressed synchronous memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MEM_BYTES = 32000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemSize;
  logic [31:0] A_Ram;
  logic [31:0] WriteData;
  logic [31:0] ReadData = '0;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemSize    (MemSize),
    .A_Ram      (A_Ram),
    .WriteData  (WriteData),
    .ReadData   (ReadData)
  );

  always #5 clk = ~clk;

  // Memory model: registered read data, byte/half/word writes at the given byte address.
  logic [7:0]  mem [0:32767];
  logic [14:0] ma;
  logic [14:0] wa;
  assign ma = A_Ram[14:0];
  assign wa = {A_Ram[14:2], 2'b00};

  always @(posedge clk) begin
    if (MemRead)
      ReadData <= {mem[15'(wa + 15'd3)], mem[15'(wa + 15'd2)], mem[15'(wa + 15'd1)], mem[wa]};
    if (MemWrite) begin
      mem[ma] <= WriteData[7:0];
      if (MemSize == SZ_H || MemSize == SZ_W)
        mem[15'(ma + 15'd1)] <= WriteData[15:8];
      if (MemSize == SZ_W) begin
        mem[15'(ma + 15'd2)] <= WriteData[23:16];
        mem[15'(ma + 15'd3)] <= WriteData[31:24];
      end
    end
  end

  // Beat monitor, sampled mid-cycle.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] rd_a_q[$];
  logic [2:0]  rd_sz_q[$];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  logic [2:0]  wr_sz_q[$];

  always @(negedge clk) begin
    if (MemRead && MemWrite) both_cnt++;
    if (MemRead) begin
      rd_cnt++;
      rd_a_q.push_back(A_Ram);
      rd_sz_q.push_back(MemSize);
    end
    if (MemWrite) begin
      wr_cnt++;
      wr_a_q.push_back(A_Ram);
      wr_d_q.push_back(WriteData);
      wr_sz_q.push_back(MemSize);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    mem[15'(a[14:0])]          <= w[7:0];
    mem[15'(a[14:0] + 15'd1)]  <= w[15:8];
    mem[15'(a[14:0] + 15'd2)]  <= w[23:16];
    mem[15'(a[14:0] + 15'd3)]  <= w[31:24];
  endtask

  // One request from an IDLE negedge through the cycle after its response.
  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_rd, input int exp_wr);
    int rd0, wr0, lat, n;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic saw;

    preload(32'h100, 32'h8899AABB);
    preload(32'h204, 32'h00001111);
    preload(32'h208, 32'hAAAAAAAA);
    preload(32'h7CFC, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rst_mem_bus", {29'd0, MemSize} | A_Ram | WriteData, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Loads from word 0x100 = 0x8899AABB.
    run("lb_101", 1'b0, F3_B, 32'h101, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 1, 0);
    check("lb_101_addr", rd_a_q[rd_a_q.size() - 1], 32'h100);
    check("lb_101_size", 32'(rd_sz_q[rd_sz_q.size() - 1]), 32'(SZ_W));
    run("lhu_102", 1'b0, F3_HU, 32'h102, 32'h0, 3, 32'h00008899, 1'b0, 1, 0);
    run("lh_102", 1'b0, F3_H, 32'h102, 32'h0, 3, 32'hFFFF8899, 1'b0, 1, 0);
    run("lw_100", 1'b0, F3_W, 32'h100, 32'h0, 3, 32'h8899AABB, 1'b0, 1, 0);
    run("lbu_103", 1'b0, F3_BU, 32'h103, 32'h0, 3, 32'h00000088, 1'b0, 1, 0);

    // Offset-2 halfword store goes out as two byte beats.
    run("sh_206", 1'b1, F3_H, 32'h206, 32'h0000BEEF, 3, 32'h0, 1'b0, 0, 2);
    base = (wr_a_q.size() >= 2) ? wr_a_q.size() - 2 : 0;
    check("sh_206_b0_addr", wr_a_q[base], 32'h206);
    check("sh_206_b0_data", wr_d_q[base], 32'h000000EF);
    check("sh_206_b0_size", 32'(wr_sz_q[base]), 32'(SZ_B));
    check("sh_206_b1_addr", wr_a_q[base + 1], 32'h207);
    check("sh_206_b1_data", wr_d_q[base + 1], 32'h000000BE);
    check("sh_206_b1_size", 32'(wr_sz_q[base + 1]), 32'(SZ_B));
    run("lw_204", 1'b0, F3_W, 32'h204, 32'h0, 3, 32'hBEEF1111, 1'b0, 1, 0);

    // Rejected requests: one-cycle error response, no memory traffic, rdata cleared.
    run("err_lw_102", 1'b0, F3_W, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("err_sh_201", 1'b1, F3_H, 32'h201, 32'hFFFF, 1, 32'h0, 1'b1, 0, 0);
    run("err_lb_range", 1'b0, F3_B, MEM_BYTES, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("err_st_bu", 1'b1, F3_BU, 32'h300, 32'h55, 1, 32'h0, 1'b1, 0, 0);

    // Offset-0 halfword store is a single half beat.
    run("sh_208", 1'b1, F3_H, 32'h208, 32'h1234CAFE, 2, 32'h0, 1'b0, 0, 1);
    check("sh_208_size", 32'(wr_sz_q[wr_sz_q.size() - 1]), 32'(SZ_H));
    check("sh_208_data", wr_d_q[wr_d_q.size() - 1], 32'h1234CAFE);
    run("lw_208", 1'b0, F3_W, 32'h208, 32'h0, 3, 32'hAAAACAFE, 1'b0, 1, 0);
    run("lw_top", 1'b0, F3_W, 32'h7CFC, 32'h0, 3, 32'hCAFEF00D, 1'b0, 1, 0);

    // Back-to-back with req_valid held: SW then LW to the same word.
    base = wr_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h300;
    req_wdata  = 32'h12345678;
    @(negedge clk);
    check("b2b_busy1", 32'(req_ready), 32'd0);
    req_we    = 1'b0;
    req_wdata = 32'h0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_st_latency", 32'(n), 32'd2);
    check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("b2b_busy2", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ld_latency", 32'(n), 32'd3);
    check("b2b_ld_rdata", rsp_rdata, 32'h12345678);
    check("b2b_writes", 32'(wr_cnt - base), 32'd1);
    @(negedge clk);

    // Reset while the split store is in its high-byte beat.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'h20A;
    req_wdata  = 32'h00005A5A;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst_beat0", 32'(MemWrite), 32'd1);
    @(negedge clk);
    check("mid_rst_sthi_addr", A_Ram, 32'h20B);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_memwrite", 32'(MemWrite), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_bus", {29'd0, MemSize} | A_Ram | WriteData, 32'd0);
    check("mid_rst_rsp", {31'd0, rsp_valid} | rsp_rdata, 32'd0);
    saw = rsp_valid;
    repeat (3) begin
      @(negedge clk);
      saw = saw | rsp_valid;
    end
    resetn = 1'b1;
    @(negedge clk);
    saw = saw | rsp_valid;
    check("mid_rst_no_rsp", 32'(saw), 32'd0);
    run("post_rst_lb", 1'b0, F3_B, 32'h101, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 1, 0);

    check("strobe_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
